// File: rtl/r8atm_pkg.sv
// Shared types and helpers for the radix-8 Booth multiplier family.
package r8atm_pkg;

  localparam int WIDTH_OP = 16;
  localparam int WIDTH_P  = 32;
  localparam int NDIG     = 6;
  localparam int AP_LOA_W = 4;

  typedef enum logic [1:0] {IDLE, PREP, ACC, DONE} state_t;

  typedef logic signed [3:0] booth_digit_t;

  // {b3,b2,b1,b0} -> {neg, |d|}, with d = -4*b3 + 2*b2 + b1 + b0
  function automatic logic [3:0] booth_r8_decode(input logic [3:0] b);
    booth_digit_t d;
    booth_digit_t mag;
    d   = booth_digit_t'({b[3], b[3], b[2], 1'b0})
        + booth_digit_t'({3'b000, b[1]})
        + booth_digit_t'({3'b000, b[0]});
    mag = d[3] ? -d : d;
    return {d[3], mag[2:0]};
  endfunction

endpackage

// File: rtl/ap_adder.sv
// Hard-multiple adder producing 3Y = Y + 2Y; lower-part-OR approximation when APPROX=1.
module ap_adder
  import r8atm_pkg::*;
#(
  parameter int APPROX = 1
) (
  input  logic [WIDTH_OP-1:0] i_y,
  output logic [WIDTH_OP+1:0] o_y3
);

  logic [WIDTH_OP+1:0] w_a;
  logic [WIDTH_OP+1:0] w_b;

  assign w_a = {i_y[WIDTH_OP-1], i_y[WIDTH_OP-1], i_y};
  assign w_b = {i_y[WIDTH_OP-1], i_y, 1'b0};

  generate
    if (APPROX == 0) begin : g_exact
      assign o_y3 = w_a + w_b;
    end else begin : g_loa
      logic [AP_LOA_W-1:0]          w_lo;
      logic                         w_cin;
      logic [WIDTH_OP+1-AP_LOA_W:0] w_hi;
      // low bits OR-ed, only the top low-bit pair feeds a carry upward
      assign w_lo  = w_a[AP_LOA_W-1:0] | w_b[AP_LOA_W-1:0];
      assign w_cin = w_a[AP_LOA_W-1] & w_b[AP_LOA_W-1];
      assign w_hi  = w_a[WIDTH_OP+1:AP_LOA_W] + w_b[WIDTH_OP+1:AP_LOA_W]
                   + {{(WIDTH_OP+1-AP_LOA_W){1'b0}}, w_cin};
      assign o_y3  = {w_hi, w_lo};
    end
  endgenerate

endmodule

// File: rtl/r8_seq_mul_ctrl.sv
// Iterative radix-8 Booth multiplier: one 3Y precompute cycle, then one Booth digit per cycle.
module r8_seq_mul_ctrl
  import r8atm_pkg::*;
#(
  parameter int APPROX = 1,
  parameter int WIDTH  = WIDTH_OP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_P-1:0] out_p,
  output logic               busy
);

  state_t r_state;
  state_t w_state_nxt;

  logic                      w_accept;
  logic                      w_last;
  logic [2:0]                r_cnt;
  logic signed [WIDTH-1:0]   r_x;
  logic signed [WIDTH-1:0]   r_y;
  logic [WIDTH+1:0]          w_y3_hm;
  logic signed [WIDTH_P-1:0] r_y3;
  logic signed [WIDTH_P-1:0] r_acc;
  logic signed [WIDTH_P-1:0] r_p;
  logic signed [WIDTH_P-1:0] w_y32;
  logic signed [WIDTH_P-1:0] w_mult;
  logic signed [WIDTH_P-1:0] w_pp;
  logic signed [WIDTH_P-1:0] w_acc_nxt;
  logic [WIDTH+2:0]          w_xe;
  logic [4:0]                w_shamt;
  logic [3:0]                w_dbits;
  logic [3:0]                w_dec;

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_last    = (r_cnt == 3'(NDIG - 1));
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_p     = r_p;

  ap_adder #(.APPROX(APPROX)) u_ap (
    .i_y  (r_y),
    .o_y3 (w_y3_hm)
  );

  // x sign-extended to 18 bits with the implicit x[-1]=0 at the bottom
  assign w_xe    = {r_x[WIDTH-1], r_x[WIDTH-1], r_x, 1'b0};
  assign w_shamt = {1'b0, r_cnt, 1'b0} + {2'b00, r_cnt};
  assign w_dbits = w_xe[w_shamt +: 4];
  assign w_dec   = booth_r8_decode(w_dbits);
  assign w_y32   = {{(WIDTH_P-WIDTH){r_y[WIDTH-1]}}, r_y};

  always_comb begin
    w_mult = '0;
    case (w_dec[2:0])
      3'd1:    w_mult = w_y32;
      3'd2:    w_mult = w_y32 << 1;
      3'd3:    w_mult = r_y3;
      3'd4:    w_mult = w_y32 << 2;
      default: w_mult = '0;
    endcase
    w_pp      = w_dec[3] ? (~w_mult + 32'sd1) : w_mult;
    w_acc_nxt = r_acc + (w_pp << w_shamt);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = PREP;
      PREP:                   w_state_nxt = ACC;
      ACC:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                                r_cnt <= '0;
    else if ((r_state == ACC) && !w_last)   r_cnt <= r_cnt + 3'd1;
    else                                    r_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_x <= in_x;
      r_y <= in_y;
    end
    if (r_state == PREP) r_y3 <= {{(WIDTH_P-WIDTH-2){w_y3_hm[WIDTH+1]}}, w_y3_hm};
  end

  // accumulator and product register are architecturally visible after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_p   <= '0;
    end else begin
      if (w_accept)                          r_acc <= '0;
      else if (r_state == ACC)               r_acc <= w_acc_nxt;
      if ((r_state == ACC) && w_last)        r_p   <= w_acc_nxt;
    end
  end

endmodule

// File: tb/tb_r8_seq_mul_ctrl.sv
// Scoreboard bench: exact and approximate sequencers driven side by side.
module tb_r8_seq_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_x = '0;
  logic [15:0] in_y = '0;
  logic        out_ready = 1'b1;

  logic        in_ready_ex, out_valid_ex, busy_ex;
  logic [31:0] out_p_ex;
  logic        in_ready_ap, out_valid_ap, busy_ap;
  logic [31:0] out_p_ap;

  always #5 clk = ~clk;

  r8_seq_mul_ctrl #(.APPROX(0)) u_dut_ex (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_ex),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid_ex), .out_ready(out_ready),
    .out_p(out_p_ex), .busy(busy_ex)
  );

  r8_seq_mul_ctrl #(.APPROX(1)) u_dut_ap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_ap),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid_ap), .out_ready(out_ready),
    .out_p(out_p_ap), .busy(busy_ap)
  );

  typedef struct {
    logic [31:0] ex;
    logic [31:0] ap;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_push  = 0;
  int   n_pop   = 0;
  bit   drv_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_ex(input logic [15:0] x, input logic [15:0] y);
    return 32'(int'($signed(x)) * int'($signed(y)));
  endfunction

  // Booth digit walk with the lower-part-OR 3Y (4 OR-ed low bits)
  function automatic logic [31:0] model_ap(input logic [15:0] x, input logic [15:0] y);
    int yi, a, b, lo, c, y3, xi, acc;
    yi  = int'($signed(y));
    a   = yi;
    b   = 2 * yi;
    lo  = (a | b) & 15;
    c   = ((a & b) >> 3) & 1;
    y3  = ((a >>> 4) + (b >>> 4) + c) * 16 + lo;
    xi  = int'($signed(x)) * 2;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      int bits, d, m;
      bits = (xi >>> (3 * i)) & 15;
      d    = -4 * ((bits >> 3) & 1) + 2 * ((bits >> 2) & 1) + ((bits >> 1) & 1) + (bits & 1);
      m    = (d == 3 || d == -3) ? y3 : ((d < 0) ? -d : d) * yi;
      acc  = acc + (((d < 0) ? -m : m) << (3 * i));
    end
    return 32'(acc);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      n_push = n_push - sb_q.size();
      sb_q.delete();
    end else begin
      if (out_valid_ex && out_ready) begin
        chk("sb_depth", 32'(sb_q.size() != 0), 32'd1);
        chk("ap_valid", 32'(out_valid_ap), 32'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          chk("p_exact", out_p_ex, mon_e.ex);
          chk("p_approx", out_p_ap, mon_e.ap);
          n_pop++;
        end
      end
      if (in_valid && in_ready_ex) begin
        mon_e.ex = model_ex(in_x, in_y);
        mon_e.ap = model_ap(in_x, in_y);
        sb_q.push_back(mon_e);
        n_push++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y);
    bit ok;
    ok       = 1'b0;
    in_x     = x;
    in_y     = y;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic taken;
      taken = in_ready_ex;
      tick();
      if (taken) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    chk("accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid_ex && lat < 40) begin
      tick();
      lat++;
    end
    chk("valid_seen", 32'(out_valid_ex), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] hold;
    logic [15:0] rx, ry;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready_ex), 32'd1);
    chk("rst_out_valid", 32'(out_valid_ex), 32'd0);
    chk("rst_out_p", out_p_ex, 32'd0);
    chk("rst_busy", 32'(busy_ex), 32'd0);
    rst = 1'b0;
    tick();

    // latency: consumer samples out_valid=1 at the 8th edge after accept
    out_ready = 1'b1;
    send(16'd3, 16'd5);
    chk("in_ready_low", 32'(in_ready_ex), 32'd0);
    chk("busy_high", 32'(busy_ex), 32'd1);
    wait_valid(lat);
    chk("valid_cycle", 32'(lat + 1), 32'd8);
    chk("p_3x5", out_p_ex, 32'h0000000F);
    tick();
    chk("in_ready_back", 32'(in_ready_ex), 32'd1);
    chk("valid_drop", 32'(out_valid_ex), 32'd0);

    send(16'h8000, 16'h8000);
    wait_valid(lat);
    chk("p_min_min", out_p_ex, 32'h40000000);
    tick();
    send(16'h7FFF, 16'hFFFF);
    wait_valid(lat);
    chk("p_max_m1", out_p_ex, 32'hFFFF8001);
    tick();
    send(16'h0DB6, 16'h1234);
    wait_valid(lat);
    chk("p_digits3", out_p_ex, 32'h00F994F8);
    tick();

    out_ready = 1'b0;
    send(16'h1111, 16'hF00D);
    wait_valid(lat);
    hold = out_p_ex;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_x     = 16'($urandom);
      in_y     = 16'($urandom);
      tick();
      chk("stall_valid", 32'(out_valid_ex), 32'd1);
      chk("stall_p", out_p_ex, hold);
      chk("stall_in_ready", 32'(in_ready_ex), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("stall_release_valid", 32'(out_valid_ex), 32'd0);
    chk("stall_release_ready", 32'(in_ready_ex), 32'd1);

    send(16'd100, 16'd200);
    repeat (3) tick();
    chk("mid_busy", 32'(busy_ex), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready_ex), 32'd1);
    chk("mid_rst_valid", 32'(out_valid_ex), 32'd0);
    chk("mid_rst_p", out_p_ex, 32'd0);
    chk("mid_rst_busy", 32'(busy_ex), 32'd0);
    send(16'd2, 16'd7);
    wait_valid(lat);
    chk("p_2x7", out_p_ex, 32'h0000000E);
    tick();

    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          case ($urandom_range(0, 7))
            0:       rx = 16'h8000;
            1:       rx = 16'h7FFF;
            2:       rx = 16'hFFFF;
            default: rx = 16'($urandom);
          endcase
          ry = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
          repeat ($urandom_range(0, 2)) tick();
          send(rx, ry);
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    chk("push_pop", 32'(n_pop), 32'(n_push));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
